// File: rtl/pg_pkg.sv
// Shared types and the per-bit generate/propagate/half-sum function
// used by the prefix adder front end.
package pg_pkg;

    typedef enum logic {
        PROP_MODE_OR  = 1'b0,
        PROP_MODE_XOR = 1'b1
    } prop_mode_e;

    localparam int GHP_W = 3;

    // Returns {gen, prop, half_sum} for one bit position.
    function automatic logic [GHP_W-1:0] pg_bit_f(
        input logic       x,
        input logic       y,
        input prop_mode_e mode
    );
        logic p;
        p = (mode == PROP_MODE_XOR) ? (x ^ y) : (x | y);
        return {x & y, p, x ^ y};
    endfunction

endpackage

// File: rtl/pg_bit.sv
// One bit of the prefix adder front end: generate, propagate and half-sum.
module pg_bit
    import pg_pkg::*;
#(
    parameter int PROP_XOR = 0
) (
    input  logic x,
    input  logic y,
    output logic gen,
    output logic prop,
    output logic half_sum
);

    localparam prop_mode_e MODE = (PROP_XOR != 0) ? PROP_MODE_XOR : PROP_MODE_OR;

    logic [GHP_W-1:0] ghp;

    assign ghp                  = pg_bit_f(x, y, MODE);
    assign {gen, prop, half_sum} = ghp;

endmodule

// File: rtl/pg_cell.sv
// Prefix adder front end: per-bit gen/prop/half_sum vectors plus the bit-0
// generate with carry-in folded in, optionally registered on a pipeline boundary.
module pg_cell
    import pg_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int PROP_XOR     = 0,
    parameter int REGISTER_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] gen,
    output logic [WIDTH-1:0] prop,
    output logic [WIDTH-1:0] half_sum,
    output logic             g0c
);

    logic [WIDTH-1:0] gen_c;
    logic [WIDTH-1:0] prop_c;
    logic [WIDTH-1:0] half_c;
    logic             g0c_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pg_bit #(
            .PROP_XOR (PROP_XOR)
        ) u_bit (
            .x        (x[i]),
            .y        (y[i]),
            .gen      (gen_c[i]),
            .prop     (prop_c[i]),
            .half_sum (half_c[i])
        );
    end

    // Correct for either propagate flavour: when both bits are set gen already covers it.
    assign g0c_c = gen_c[0] | (prop_c[0] & cin);

    if (REGISTER_OUT != 0) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                gen       <= '0;
                prop      <= '0;
                half_sum  <= '0;
                g0c       <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    gen      <= gen_c;
                    prop     <= prop_c;
                    half_sum <= half_c;
                    g0c      <= g0c_c;
                end
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out_valid = in_valid;
        assign gen       = gen_c;
        assign prop      = prop_c;
        assign half_sum  = half_c;
        assign g0c       = g0c_c;
    end

endmodule

// File: tb/tb_pg_cell.sv
// Scoreboard bench for pg_cell: registered WIDTH=16/1 instances plus
// combinational instances checked against an arithmetic reference model.
module tb_pg_cell;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        cin = 1'b0;

    logic        a_ov, a_g0c;
    logic [15:0] a_gen, a_prop, a_half;
    logic        b_ov, b_g0c;
    logic [0:0]  b_gen, b_prop, b_half;
    logic        c_ov, c_g0c;
    logic [0:0]  c_gen, c_prop, c_half;

    logic        cv = 1'b0;
    logic [15:0] cx = '0;
    logic [15:0] cy = '0;
    logic        cc = 1'b0;
    logic        d_ov, d_g0c, e_ov, e_g0c;
    logic [15:0] d_gen, d_prop, d_half, e_gen, e_prop, e_half;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pg_cell #(.WIDTH(16), .PROP_XOR(0), .REGISTER_OUT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .cin(cin),
        .out_valid(a_ov), .gen(a_gen), .prop(a_prop), .half_sum(a_half), .g0c(a_g0c));
    pg_cell #(.WIDTH(1), .PROP_XOR(0), .REGISTER_OUT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x[0:0]), .y(y[0:0]), .cin(cin),
        .out_valid(b_ov), .gen(b_gen), .prop(b_prop), .half_sum(b_half), .g0c(b_g0c));
    pg_cell #(.WIDTH(1), .PROP_XOR(1), .REGISTER_OUT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x[0:0]), .y(y[0:0]), .cin(cin),
        .out_valid(c_ov), .gen(c_gen), .prop(c_prop), .half_sum(c_half), .g0c(c_g0c));
    pg_cell #(.WIDTH(16), .PROP_XOR(0), .REGISTER_OUT(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(cv), .x(cx), .y(cy), .cin(cc),
        .out_valid(d_ov), .gen(d_gen), .prop(d_prop), .half_sum(d_half), .g0c(d_g0c));
    pg_cell #(.WIDTH(16), .PROP_XOR(1), .REGISTER_OUT(0)) u_e (
        .clk(clk), .rst_n(rst_n), .in_valid(cv), .x(cx), .y(cy), .cin(cc),
        .out_valid(e_ov), .gen(e_gen), .prop(e_prop), .half_sum(e_half), .g0c(e_g0c));

    typedef struct {
        logic        v;
        logic [15:0] g16, p16, h16;
        logic        c16;
        logic        g1, h1, p1o, p1x;
    } exp_t;

    exp_t q[$];
    exp_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Carry out of a 1-bit add of x[0]+y[0]+cin is the bit-0 generate with carry-in.
    function automatic logic carry0(input logic a, input logic b, input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        return (s >= 2);
    endfunction

    function automatic exp_t model(input logic v, input logic [15:0] a, input logic [15:0] b,
                                   input logic c);
        exp_t e;
        e.v   = v;
        e.g16 = a & b;
        e.h16 = a ^ b;
        e.p16 = a | b;
        e.c16 = carry0(a[0], b[0], c);
        e.g1  = a[0] & b[0];
        e.h1  = a[0] ^ b[0];
        e.p1o = a[0] | b[0];
        e.p1x = a[0] ^ b[0];
        return e;
    endfunction

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
        in_valid = v;
        x        = a;
        y        = b;
        cin      = c;
        q.push_back(model(v, a, b, c));
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"},   {a_ov, b_ov, c_ov}, 64'h0);
        chk({tag, "_gen"},  {a_gen, b_gen, c_gen}, 64'h0);
        chk({tag, "_prop"}, {a_prop, b_prop, c_prop}, 64'h0);
        chk({tag, "_half"}, {a_half, b_half, c_half}, 64'h0);
        chk({tag, "_g0c"},  {a_g0c, b_g0c, c_g0c}, 64'h0);
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            held = model(1'b0, 16'h0, 16'h0, 1'b0);
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ov16", a_ov, e.v);
            chk("ov1_or", b_ov, e.v);
            chk("ov1_xor", c_ov, e.v);
            if (e.v) held = e;
            chk("gen16", a_gen, held.g16);
            chk("prop16", a_prop, held.p16);
            chk("half16", a_half, held.h16);
            chk("g0c16", a_g0c, held.c16);
            chk("ghp1_or", {b_gen, b_prop, b_half}, {held.g1, held.p1o, held.h1});
            chk("g0c1_or", b_g0c, held.c16);
            chk("ghp1_xor", {c_gen, c_prop, c_half}, {held.g1, held.p1x, held.h1});
            chk("g0c1_xor", c_g0c, held.c16);
        end
    end

    initial begin
        logic [15:0] ra, rb;
        #1 rst_n = 1'b0;
        #2 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-bit sweep, cin=0
        for (int i = 0; i < 4; i++) begin
            ra = 16'(i >> 1);
            rb = 16'(i & 1);
            step(1'b1, ra, rb, 1'b0);
        end

        step(1'b1, 16'h00F1, 16'h0010, 1'b1);
        step(1'b1, 16'h0000, 16'h0000, 1'b1);
        step(1'b1, 16'h0001, 16'h0001, 1'b0);

        // load then hold through three idle cycles with junk inputs
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));

        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom));

        // async reset while out_valid is high
        step(1'b1, 16'hA5C3, 16'h3C5A, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h1234, 16'h4321, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 50; i++)
            step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        in_valid = 1'b0;
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'h0);

        // combinational instances
        for (int i = 0; i < 1000; i++) begin
            cv = 1'($urandom);
            cx = 16'($urandom);
            cy = 16'($urandom);
            cc = 1'($urandom);
            #1;
            chk("c_ov_or", d_ov, cv);
            chk("c_ov_xor", e_ov, cv);
            chk("c_gen", {d_gen, e_gen}, {cx & cy, cx & cy});
            chk("c_half", {d_half, e_half}, {cx ^ cy, cx ^ cy});
            chk("c_prop_or", d_prop, cx | cy);
            chk("c_prop_xor", e_prop, cx ^ cy);
            chk("c_g0c", {d_g0c, e_g0c}, {2{carry0(cx[0], cy[0], cc)}});
            chk("c_inv_gh", {d_gen & d_half, e_gen & e_half}, 64'h0);
            chk("c_inv_or", d_prop, d_gen | d_half);
            chk("c_inv_xor", e_prop, e_half);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
